ssd_xfer_sequencer: RTL and testbench

//  Parametrised successor to the switch-driven WR/RD start logic. Turns a front-panel or host

---
 rtl/ssd_xfer_sequencer_if.sv | 28 ++
 rtl/ssd_xfer_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ssd_xfer_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_xfer_sequencer_if.sv
// Command-layer handshake bundle for ssd_xfer_sequencer.
//   cmd_valid/cmd_ready : request handshake (sequencer -> command layer)
//   cmd_wr              : 1=write, 0=read, meaningful with cmd_valid
//   cmd_lba/cmd_cnt     : start LBA and sector count of the command
//   cmd_done/cmd_err    : 1-cycle completion pulse, err qualifies done
// master = sequencer side, slave = command layer side.
interface ssd_xfer_sequencer_if #(
  parameter int LBA_W = 48,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic [LBA_W-1:0] cmd_lba;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_done;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_wr, cmd_lba, cmd_cnt,
    input  cmd_ready, cmd_done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_lba, cmd_cnt,
    output cmd_ready, cmd_done, cmd_err
  );
endinterface

// File: rtl/ssd_xfer_sequencer.sv
// ssd_xfer_sequencer: turns a write/read request over an inclusive LBA range
// into a series of commands of at most MAX_SECT sectors, one in flight at a
// time, with range check, abort and completion status.
// Ports:
//   clk, nRST            clock, async active-low reset
//   sw_wr, sw_rd, abort  async levels; sw_wr/sw_rd rising edge starts a transfer
//   lba_begin, lba_end   inclusive range, sampled at start
//   cmd                  command-layer handshake (master modport)
//   busy                 transfer in progress
//   nWRpRD               0=write, 1=read, held for the transfer
//   done, err            1-cycle completion pulses
//   sect_done            sectors completed in the current/last transfer
module ssd_xfer_sequencer #(
  parameter int LBA_W       = 48,
  parameter int CNT_W       = 16,
  parameter int MAX_SECT    = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 sw_wr,
  input  logic                 sw_rd,
  input  logic                 abort,
  input  logic [LBA_W-1:0]     lba_begin,
  input  logic [LBA_W-1:0]     lba_end,
  ssd_xfer_sequencer_if.master cmd,
  output logic                 busy,
  output logic                 nWRpRD,
  output logic                 done,
  output logic                 err,
  output logic [LBA_W:0]       sect_done
);
  localparam int RW = LBA_W + 1;
  localparam logic [RW-1:0]    MAX_R = RW'(MAX_SECT);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SECT);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT} state_t;

  // ---- synchronisers: bit0 sw_wr, bit1 sw_rd, bit2 abort ----
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  lvl_prev_q;
  logic [2:0]                  lvl;
  logic                        start_wr, start_rd, abort_lvl;

  assign lvl       = sync_q[SYNC_STAGES-1];
  assign start_wr  = lvl[0] & ~lvl_prev_q[0];
  assign start_rd  = lvl[1] & ~lvl_prev_q[1];
  assign abort_lvl = lvl[2];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync_q     <= '0;
      lvl_prev_q <= '0;
    end else begin
      sync_q[0] <= {abort, sw_rd, sw_wr};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      lvl_prev_q <= lvl;
    end
  end

  // ---- transfer state ----
  state_t           state_q;
  logic [LBA_W-1:0] beg_q, end_q, cur_lba_q;
  logic [RW-1:0]    rem_q, sect_q;
  logic             abort_q, busy_q, nwrprd_q, done_q, err_q;
  logic             cvalid_q, cwr_q;
  logic [LBA_W-1:0] clba_q;
  logic [CNT_W-1:0] ccnt_q;

  // Span is computed one bit wider so a full 0..2**LBA_W-1 range fits.
  logic [RW-1:0]    span_d, rem_d;
  logic [LBA_W-1:0] lba_d;

  assign span_d = {1'b0, end_q} - {1'b0, beg_q} + RW'(1);
  assign rem_d  = rem_q - RW'(ccnt_q);
  assign lba_d  = cur_lba_q + LBA_W'(ccnt_q);

  function automatic logic [CNT_W-1:0] chunk(input logic [RW-1:0] r);
    chunk = (r > MAX_R) ? MAX_C : r[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      beg_q     <= '0;
      end_q     <= '0;
      cur_lba_q <= '0;
      rem_q     <= '0;
      sect_q    <= '0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      nwrprd_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cvalid_q  <= 1'b0;
      cwr_q     <= 1'b0;
      clba_q    <= '0;
      ccnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start_wr || start_rd) begin
            beg_q    <= lba_begin;
            end_q    <= lba_end;
            nwrprd_q <= ~start_wr;   // write wins on simultaneous edges
            sect_q   <= '0;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (beg_q > end_q) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cur_lba_q <= beg_q;
            rem_q     <= span_d;
            busy_q    <= 1'b1;
            cvalid_q  <= 1'b1;
            cwr_q     <= ~nwrprd_q;
            clba_q    <= beg_q;
            ccnt_q    <= chunk(span_d);
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // cvalid_q is always set here, so ready alone completes the handshake.
          if (abort_lvl) abort_q <= 1'b1;
          if (cmd.cmd_ready) begin
            cvalid_q <= 1'b0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort_lvl) abort_q <= 1'b1;
          if (cmd.cmd_done) begin
            if (cmd.cmd_err) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              abort_q <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cur_lba_q <= lba_d;
              rem_q     <= rem_d;
              sect_q    <= sect_q + RW'(ccnt_q);
              if (rem_d == '0) begin
                // range finished: a pending abort no longer matters
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                abort_q <= 1'b0;
                state_q <= S_IDLE;
              end else if (abort_q || abort_lvl) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                abort_q <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                cvalid_q <= 1'b1;
                clba_q   <= lba_d;
                ccnt_q   <= chunk(rem_d);
                state_q  <= S_ISSUE;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_valid = cvalid_q;
  assign cmd.cmd_wr    = cwr_q;
  assign cmd.cmd_lba   = clba_q;
  assign cmd.cmd_cnt   = ccnt_q;
  assign busy          = busy_q;
  assign nWRpRD        = nwrprd_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sect_done     = sect_q;
endmodule

// File: tb/tb_ssd_xfer_sequencer.sv
module tb_ssd_xfer_sequencer;
  localparam int LBA_W = 48, CNT_W = 16, MAX = 256, SS = 2;

  logic clk = 1'b0, nRST = 1'b0, sw_wr = 1'b0, sw_rd = 1'b0, abort = 1'b0;
  logic [LBA_W-1:0] lba_begin = '0, lba_end = '0;
  logic busy, nWRpRD, done, err;
  logic [LBA_W:0] sect_done;

  ssd_xfer_sequencer_if #(.LBA_W(LBA_W), .CNT_W(CNT_W)) cif();

  ssd_xfer_sequencer #(.LBA_W(LBA_W), .CNT_W(CNT_W), .MAX_SECT(MAX), .SYNC_STAGES(SS)) dut (
    .clk(clk), .nRST(nRST), .sw_wr(sw_wr), .sw_rd(sw_rd), .abort(abort),
    .lba_begin(lba_begin), .lba_end(lba_end), .cmd(cif.master),
    .busy(busy), .nWRpRD(nWRpRD), .done(done), .err(err), .sect_done(sect_done)
  );

  always #5 clk = ~clk;

  int vecs = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---- reference model of the transfer in progress ----
  longint m_begin = 0, m_total = 0;
  bit     m_wr = 0, slow = 0;
  int     m_err_at = -1, m_abort_at = -1, nseen = 0, hold_cnt = 0;
  longint log_lba [8];
  longint log_cnt [8];

  // Command-layer responder plus the per-cycle compare against the model.
  initial begin : resp
    bit pend, pv, phs, pwr;
    int dly;
    logic [LBA_W-1:0] plba;
    logic [CNT_W-1:0] pcnt;
    longint rem, ecnt;
    int k;
    pend = 0; pv = 0; phs = 0; pwr = 0; dly = 0; plba = '0; pcnt = '0;
    cif.cmd_ready = 1'b0; cif.cmd_done = 1'b0; cif.cmd_err = 1'b0;
    forever begin
      @(negedge clk);
      cif.cmd_done = 1'b0; cif.cmd_err = 1'b0;
      if (!nRST) begin
        pend = 0; pv = 0; phs = 0; cif.cmd_ready = 1'b0;
        continue;
      end
      if (pv && !phs) begin
        chk("hold_valid", cif.cmd_valid, 1);
        chk("hold_lba", cif.cmd_lba, plba);
        chk("hold_cnt", cif.cmd_cnt, pcnt);
        chk("hold_wr", cif.cmd_wr, pwr);
      end
      if (pend) begin
        chk("one_in_flight", cif.cmd_valid, 0);
        if (dly == 0) begin
          cif.cmd_done = 1'b1;
          cif.cmd_err  = (m_err_at == nseen - 1);
          pend = 0;
        end else dly--;
      end
      if (busy) chk("dir", nWRpRD, !m_wr);
      if (hold_cnt > 0) begin
        cif.cmd_ready = 1'b0;
        hold_cnt--;
      end else cif.cmd_ready = ($urandom_range(0, 2) != 0);
      if (cif.cmd_valid && cif.cmd_ready) begin
        k    = nseen;
        rem  = m_total - longint'(k) * MAX;
        ecnt = (rem > MAX) ? MAX : rem;
        chk("cmd_wr", cif.cmd_wr, m_wr);
        chk("cmd_lba", cif.cmd_lba, m_begin + longint'(k) * MAX);
        chk("cmd_cnt", cif.cmd_cnt, ecnt);
        if (k < 8) begin
          log_lba[k] = longint'(cif.cmd_lba);
          log_cnt[k] = longint'(cif.cmd_cnt);
        end
        if (k == m_abort_at) abort = 1'b1;
        nseen++;
        pend = 1;
        dly  = (slow || k == m_abort_at) ? 12 + $urandom_range(0, 4) : $urandom_range(0, 3);
      end
      pv = cif.cmd_valid; phs = pv && cif.cmd_ready;
      plba = cif.cmd_lba; pcnt = cif.cmd_cnt; pwr = cif.cmd_wr;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {cif.cmd_valid, cif.cmd_wr, busy, nWRpRD, done, err}, 0);
    chk({tag, "_lba"}, cif.cmd_lba, 0);
    chk({tag, "_cnt"}, cif.cmd_cnt, 0);
    chk({tag, "_sect"}, sect_done, 0);
  endtask

  // One transfer: outcome, count, sector total and latency come from the
  // range arithmetic; individual commands are checked by the responder.
  task automatic run_xfer(input bit wr, input bit rd, input longint b, input longint e,
                          input int err_at, input int abort_at, input bit mid_rd, input string tag);
    bit bad, exp_done, fin;
    int ncmd, nfull, cyc, first_busy;
    longint exp_sect;
    logic [LBA_W-1:0] bb, ee;
    bad = (b > e);
    m_begin = b; m_total = bad ? 0 : e - b + 1; m_wr = wr;
    m_err_at = err_at; m_abort_at = abort_at; nseen = 0;
    nfull = int'((m_total + MAX - 1) / MAX);
    if (bad) begin
      ncmd = 0; exp_done = 0; exp_sect = 0;
    end else if (err_at >= 0 && err_at < nfull && (abort_at < 0 || err_at <= abort_at)) begin
      ncmd = err_at + 1; exp_done = 0; exp_sect = longint'(err_at) * MAX;
    end else if (abort_at >= 0 && abort_at < nfull - 1) begin
      ncmd = abort_at + 1; exp_done = 0; exp_sect = longint'(ncmd) * MAX;
    end else begin
      ncmd = nfull; exp_done = 1; exp_sect = m_total;
    end
    bb = b[LBA_W-1:0]; ee = e[LBA_W-1:0];
    @(negedge clk);
    lba_begin = bb; lba_end = ee; sw_wr = wr; sw_rd = rd;
    cyc = 0; first_busy = 0; fin = 0;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (busy && first_busy == 0) first_busy = cyc;
      if (mid_rd && first_busy != 0 && cyc == first_busy + 2) sw_rd = 1'b1;
      if (mid_rd && first_busy != 0 && cyc == first_busy + 5) sw_rd = 1'b0;
      if (done || err) begin
        fin = 1;
        chk({tag, "_result"}, {done, err}, exp_done ? 2'b10 : 2'b01);
        chk({tag, "_sect"}, sect_done, exp_sect);
        if (bad) chk({tag, "_err_lat"}, cyc, SS + 2);
      end
    end
    if (!fin) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_busy_lat"}, first_busy, bad ? 0 : SS + 2);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {done, err, busy}, 0);
    sw_wr = 1'b0; sw_rd = 1'b0; abort = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, "_ncmd"}, nseen, ncmd);
    chk({tag, "_idle"}, {busy, cif.cmd_valid}, 0);
  endtask

  initial begin : wdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint rb, len;
    int r, ea, aa, wait_cyc;
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    nRST = 1'b1;
    repeat (3) @(negedge clk);

    // single sector write
    run_xfer(1, 0, 64'h10, 64'h10, -1, -1, 0, "t1");
    chk("t1_lit_lba", log_lba[0], 64'h10);
    chk("t1_lit_cnt", log_cnt[0], 1);
    chk("t1_lit_sect", sect_done, 1);

    // 600-sector read split into 256/256/88
    run_xfer(0, 1, 0, 599, -1, -1, 0, "t2");
    chk("t2_lit_c0", {log_lba[0][31:0], log_cnt[0][31:0]}, {32'd0, 32'd256});
    chk("t2_lit_c1", {log_lba[1][31:0], log_cnt[1][31:0]}, {32'd256, 32'd256});
    chk("t2_lit_c2", {log_lba[2][31:0], log_cnt[2][31:0]}, {32'd512, 32'd88});
    chk("t2_lit_sect", sect_done, 600);
    chk("t2_lit_dir", nWRpRD, 1);

    // reversed range
    run_xfer(1, 0, 5, 4, -1, -1, 0, "t3");

    // ready held low, stray read edge while busy, then simultaneous edges
    hold_cnt = 14;
    run_xfer(1, 0, 1000, 1700, -1, -1, 1, "t4a");
    run_xfer(1, 1, 300, 310, -1, -1, 0, "t4b");
    chk("t4b_lit_dir", nWRpRD, 0);

    // error on 2nd completion, abort during cmd 1, abort during the last command
    run_xfer(1, 0, 0, 599, 1, -1, 0, "t5a");
    run_xfer(0, 1, 0, 599, -1, 0, 0, "t5b");
    chk("t5b_lit_sect", sect_done, 256);
    run_xfer(1, 0, 0, 255, -1, 0, 0, "t5c");

    // reset while a command is in flight
    slow = 1; nseen = 0; m_begin = 32; m_total = 1000; m_wr = 1; m_err_at = -1; m_abort_at = -1;
    @(negedge clk);
    lba_begin = 48'd32; lba_end = 48'd1031; sw_wr = 1'b1;
    wait_cyc = 0;
    while (nseen < 1 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("t6_reached_wait", nseen >= 1, 1);
    repeat (3) @(negedge clk);
    #2 nRST = 1'b0;
    #1 chk_zero("t6_async");
    sw_wr = 1'b0; slow = 0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    run_xfer(1, 0, 64'h40, 64'h40, -1, -1, 0, "t6b");

    // randomized transfers
    for (int i = 0; i < 10; i++) begin
      rb  = longint'({$urandom, $urandom} % 64'hFFFF_FFFF_F000);
      len = longint'($urandom_range(1, 900));
      r = $urandom_range(0, 5); ea = (r < 4) ? -1 : $urandom_range(0, 2);
      r = $urandom_range(0, 5); aa = (r < 4) ? -1 : $urandom_range(0, 2);
      r = $urandom_range(0, 2);
      run_xfer(r != 1, r != 0, rb, rb + len - 1, ea, aa, 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
